mar_seq: RTL and testbench
==========================

# mar_seq

Parametrised memory address register with built-in access sequencing for the microcontroller datapath. It holds a base address loaded from the internal bus and computes either direct or base+offset effective addresses. It runs a single-outstanding request/acknowledge access to the memory interface, with a timeout. After a completed access it can optionally post-increment by a fixed stride. It sits between the instruction/datapath control and the memory port, and its output is always driven.

## Interface
- ADDR_W, 16, address width in bits (≥4)
- OFF_W, 8, width of signed index offset (≤ ADDR_W)
- STRIDE, 1, post-increment amount (1..2^(ADDR_W-1))
- TIMEOUT, 15, max cycles to wait for mem_ack (1..255)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- addr_in  in  ADDR_W  value captured on load
- load  in  1  capture addr_in into base register
- acc_start  in  1  request one memory access
- acc_idx  in  1  sampled with acc_start: 1 = base+offset, 0 = base
- offset  in  OFF_W  signed index, sampled with acc_start
- post_inc  in  1  sampled with acc_start: update base after success
- mem_ack  in  1  memory acknowledge
- mem_req  out  1  memory request
- mem_addr  out  ADDR_W  effective address, valid while mem_req=1
- addr_out  out  ADDR_W  current base register
- busy  out  1  high in REQ state
- done  out  1  one-cycle pulse on successful access
- err  out  1  one-cycle pulse on timeout
- wrap_lo, wrap_hi  in  ADDR_W each  circular-region bounds (only with MAR_SEQ_WRAP_EN)

## Operation
- States: IDLE, REQ. Reset → IDLE.
- IDLE, load=1: base ← addr_in. If acc_start is also 1 in the same cycle, load wins and acc_start is dropped.
- IDLE, acc_start=1, load=0:
  - mem_addr ← base, or base + sign_extend(offset) when acc_idx=1. Sum is modulo 2^ADDR_W.
  - post_inc is latched.
  - Timeout counter ← 0.
  - Go to REQ.
- REQ: mem_req=1 and busy=1. mem_addr is held stable. load and acc_start are ignored.
- REQ, mem_ack=1: go to IDLE and pulse done.
  - If latched post_inc=1: base ← base + STRIDE, modulo 2^ADDR_W.
  - The base is updated even for indexed accesses; the offset is never accumulated.
- REQ, mem_ack=0: the counter increments. If the counter equals TIMEOUT-1 this cycle, go to IDLE and pulse err. The base is unchanged.
- mem_ack while IDLE is ignored.
- Reset during REQ aborts the access at the next edge. No done or err is produced.

## Timing
- Reset values:
  - mem_req=0, busy=0, done=0, err=0
  - mem_addr=0, addr_out=0
  - state=IDLE, counter=0
- load → addr_out updates on the next edge (1-cycle latency).
- acc_start at edge N → mem_req=1 and mem_addr valid from N+1.
- mem_ack sampled high at edge M (with mem_req=1) → at M+1: mem_req=0, done=1, addr_out incremented if requested.
- Minimum access is 2 cycles; the earliest next acc_start is accepted in the cycle done is high.
- No ack: mem_req stays high exactly TIMEOUT cycles. err is high for 1 cycle in the cycle after the last mem_req cycle.
- done and err are never high together.

## Configuration
- MAR_SEQ_WRAP_EN defined:
  - wrap_lo and wrap_hi ports exist.
  - Post-increment uses an (ADDR_W+1)-bit sum. If the sum > wrap_hi, base ← wrap_lo.
  - If wrap_lo > wrap_hi, behaviour is undefined.
- MAR_SEQ_WRAP_EN undefined:
  - No wrap ports.
  - Post-increment wraps modulo 2^ADDR_W only.

## Structure
- Shared package mar_seq_pkg holds:
  - the state enum (MAR_IDLE, MAR_REQ)
  - the counter-width function clog2(TIMEOUT)
- One sub-module, mar_seq_addgen: combinational effective-address and next-base computation, including the wrap logic. The FSM, registers and timeout counter stay in the top.

## Test plan
- Reset then load addr_in=16'h1234 → addr_out=16'h1234 next cycle; mem_req stays 0.
- acc_start, acc_idx=1, base=16'h00F0, offset=8'hF8 (−8) → mem_addr=16'h00E8; ack after 3 cycles → done pulse, base unchanged (post_inc=0).
- base=16'hFFFF, post_inc=1, STRIDE=1, ack in first REQ cycle → addr_out=16'h0000; total access 2 cycles.
- No ack, TIMEOUT=15 → mem_req high 15 cycles, err pulse, addr_out unchanged; then load and acc_start accepted.
- load=1 and acc_start=1 together in IDLE → base loaded, no mem_req. Load asserted during REQ → ignored.
- With MAR_SEQ_WRAP_EN, wrap_lo=16'h0100, wrap_hi=16'h01FF, base=16'h01FF, post_inc → addr_out=16'h0100.
- Reset asserted mid-REQ → mem_req=0 next edge, no done or err.

Source files
------------

// File: rtl/mar_seq_pkg.sv
// mar_seq_pkg: shared state encoding and counter sizing for the mar_seq address register.
package mar_seq_pkg;
    typedef enum logic [0:0] {MAR_IDLE, MAR_REQ} mar_state_t;

    // Smallest width able to count 0..v-1, never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mar_seq_addgen.sv
// mar_seq_addgen: effective address and post-increment base computation.
// Circular post-increment region enabled by MAR_SEQ_WRAP_EN.
module mar_seq_addgen #(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 8,
    parameter int STRIDE = 1
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    input  logic              idx,
`ifdef MAR_SEQ_WRAP_EN
    input  logic [ADDR_W-1:0] wrap_lo,
    input  logic [ADDR_W-1:0] wrap_hi,
`endif
    output logic [ADDR_W-1:0] eff_addr,
    output logic [ADDR_W-1:0] next_base
);
    assign eff_addr = idx ? base + ADDR_W'($signed(offset)) : base;
`ifdef MAR_SEQ_WRAP_EN
    // Extra carry bit so an increment past the top of the address space still counts as beyond wrap_hi.
    logic [ADDR_W:0] sum;
    assign sum       = {1'b0, base} + (ADDR_W+1)'(STRIDE);
    assign next_base = (sum > {1'b0, wrap_hi}) ? wrap_lo : sum[ADDR_W-1:0];
`else
    assign next_base = base + ADDR_W'(STRIDE);
`endif
endmodule

// File: rtl/mar_seq.sv
// mar_seq: memory address register with single-outstanding req/ack access, timeout and post-increment.
// Optional circular post-increment region via MAR_SEQ_WRAP_EN (adds wrap_lo/wrap_hi ports).
module mar_seq
    import mar_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int OFF_W   = 8,
    parameter int STRIDE  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              load,
    input  logic              acc_start,
    input  logic              acc_idx,
    input  logic [OFF_W-1:0]  offset,
    input  logic              post_inc,
    input  logic              mem_ack,
`ifdef MAR_SEQ_WRAP_EN
    input  logic [ADDR_W-1:0] wrap_lo,
    input  logic [ADDR_W-1:0] wrap_hi,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] addr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = clog2(TIMEOUT);

    mar_state_t        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] base, base_n, maddr_n, eff_addr, next_base;
    logic              pinc, pinc_n, done_n, err_n;

    mar_seq_addgen #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STRIDE(STRIDE)) u_addgen (
        .base      (base),
        .offset    (offset),
        .idx       (acc_idx),
`ifdef MAR_SEQ_WRAP_EN
        .wrap_lo   (wrap_lo),
        .wrap_hi   (wrap_hi),
`endif
        .eff_addr  (eff_addr),
        .next_base (next_base)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= MAR_IDLE;
            cnt      <= '0;
            base     <= '0;
            mem_addr <= '0;
            pinc     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            base     <= base_n;
            mem_addr <= maddr_n;
            pinc     <= pinc_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        base_n  = base;
        maddr_n = mem_addr;
        pinc_n  = pinc;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (state == MAR_IDLE) begin
            if (load) begin
                base_n = addr_in;
            end else if (acc_start) begin
                maddr_n = eff_addr;
                pinc_n  = post_inc;
                cnt_n   = '0;
                state_n = MAR_REQ;
            end
        end else if (mem_ack) begin
            state_n = MAR_IDLE;
            done_n  = 1'b1;
            base_n  = pinc ? next_base : base;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
            state_n = MAR_IDLE;
            err_n   = 1'b1;
        end else begin
            cnt_n = cnt + CW'(1);
        end
    end

    assign mem_req  = (state == MAR_REQ);
    assign busy     = (state == MAR_REQ);
    assign addr_out = base;
endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq: directed scoreboard bench for mar_seq (ADDR_W=16, OFF_W=8, STRIDE=1, TIMEOUT=15).
// Build with MAR_SEQ_WRAP_EN to also cover the circular post-increment region.
module tb_mar_seq;
    logic        clock = 1'b0;
    logic        reset, load, acc_start, acc_idx, post_inc, mem_ack;
    logic [15:0] addr_in;
    logic [7:0]  offset;
    logic        mem_req, busy, done, err;
    logic [15:0] mem_addr, addr_out;
    logic [15:0] wlo = 16'h0000, whi = 16'hFFFF;
    logic [15:0] bmodel;
    int          vectors = 0, miscompares = 0;

    typedef struct {
        logic        done;
        logic        err;
        logic [15:0] addr;
        logic [15:0] base;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    mar_seq #(.ADDR_W(16), .OFF_W(8), .STRIDE(1), .TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr_in   (addr_in),
        .load      (load),
        .acc_start (acc_start),
        .acc_idx   (acc_idx),
        .offset    (offset),
        .post_inc  (post_inc),
        .mem_ack   (mem_ack),
`ifdef MAR_SEQ_WRAP_EN
        .wrap_lo   (wlo),
        .wrap_hi   (whi),
`endif
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .addr_out  (addr_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] inc_model(input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, b} + 17'd1;
`ifdef MAR_SEQ_WRAP_EN
        return (s > {1'b0, whi}) ? wlo : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    task automatic load_base(input logic [15:0] a);
        addr_in = a;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        bmodel  = a;
        chk("load_addr_out", addr_out, a);
    endtask

    // ack_at: REQ cycle (1-based) in which mem_ack is driven; 0 means never.
    task automatic access(input string tag, input logic idx, input logic [7:0] off,
                          input logic pinc, input int ack_at, input logic ld_during);
        exp_t e, g;
        int   cycles;
        acc_idx   = idx;
        offset    = off;
        post_inc  = pinc;
        acc_start = 1'b1;
        tick();
        acc_start = 1'b0;
        e.addr    = idx ? bmodel + {{8{off[7]}}, off} : bmodel;
        e.done    = (ack_at >= 1 && ack_at <= 15);
        e.err     = !e.done;
        e.cycles  = e.done ? ack_at : 15;
        e.base    = (e.done && pinc) ? inc_model(bmodel) : bmodel;
        sb.push_back(e);
        chk({tag, "_req"}, {busy, mem_req}, 2'b11);
        cycles = 1;
        for (int i = 1; i <= 40; i++) begin
            mem_ack = (i == ack_at);
            load    = ld_during;
            addr_in = 16'hDEAD;
            chk({tag, "_addr"}, mem_addr, e.addr);
            tick();
            mem_ack = 1'b0;
            load    = 1'b0;
            if (!mem_req) break;
            cycles++;
        end
        g = sb.pop_front();
        bmodel = g.base;
        chk({tag, "_cycles"}, cycles, g.cycles);
        chk({tag, "_done_err"}, {done, err}, {g.done, g.err});
        chk({tag, "_base"}, addr_out, g.base);
        tick();
        chk({tag, "_pulse"}, {done, err}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; acc_start = 1'b0; acc_idx = 1'b0;
        post_inc = 1'b0; mem_ack = 1'b0; addr_in = '0; offset = '0; bmodel = '0;
        tick();
        tick();
        chk("rst_ctrl", {mem_req, busy, done, err}, 4'b0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_addr_out", addr_out, 16'h0000);
        reset = 1'b0;

        load_base(16'h1234);
        chk("load_no_req", mem_req, 1'b0);

        load_base(16'h00F0);
        access("idx_neg", 1'b1, 8'hF8, 1'b0, 3, 1'b0);
        chk("idx_neg_addr_val", mem_addr, 16'h00E8);

        load_base(16'hFFFF);
        access("inc_wrap0", 1'b0, 8'h00, 1'b1, 1, 1'b0);
        chk("inc_wrap0_val", addr_out, 16'h0000);

        load_base(16'h0040);
        access("timeout", 1'b0, 8'h00, 1'b1, 0, 1'b0);
        load_base(16'h0050);
        access("after_to", 1'b1, 8'h7F, 1'b1, 2, 1'b1);
        chk("after_to_val", addr_out, 16'h0051);

        addr_in = 16'h0200; load = 1'b1; acc_start = 1'b1;
        tick();
        load = 1'b0; acc_start = 1'b0; bmodel = 16'h0200;
        chk("ld_acc_base", addr_out, 16'h0200);
        chk("ld_acc_noreq", mem_req, 1'b0);
        tick();
        chk("ld_acc_noreq2", mem_req, 1'b0);

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack", {mem_req, done, err}, 3'b000);

`ifdef MAR_SEQ_WRAP_EN
        wlo = 16'h0100; whi = 16'h01FF;
        load_base(16'h01FF);
        access("wrap", 1'b0, 8'h00, 1'b1, 2, 1'b0);
        chk("wrap_val", addr_out, 16'h0100);
        wlo = 16'h0000; whi = 16'hFFFF;
`endif

        load_base(16'h0300);
        acc_idx = 1'b0; post_inc = 1'b1; acc_start = 1'b1;
        tick();
        acc_start = 1'b0;
        chk("mid_rst_req", mem_req, 1'b1);
        tick();
        reset = 1'b1; mem_ack = 1'b1;
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        chk("mid_rst_ctrl", {mem_req, busy, done, err}, 4'b0000);
        chk("mid_rst_base", addr_out, 16'h0000);
        tick();
        chk("mid_rst_after", {mem_req, done, err}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
